// File: rtl/arm_mmio_timer.sv
// Memory-mapped prescaled down-counter timer on the single-cycle CPU data bus.
// Combinational reads, edge-committed writes, sticky expiry flag and level IRQ.
module arm_mmio_timer #(
    parameter int unsigned         BusWidth = 32,
    parameter logic [BusWidth-1:0] BaseAddr = BusWidth'(32'hFFFF_0000)
) (
    input  logic                i_CLK,
    input  logic                i_RESET,
    input  logic [BusWidth-1:0] i_Address,
    input  logic [BusWidth-1:0] i_Write_Data,
    input  logic                i_Mem_Write,
    output logic [BusWidth-1:0] o_Read_Data,
    output logic                o_Hit,
    output logic                o_IRQ
);

    localparam int unsigned PreW = 16;

    localparam logic [2:0] OFS_CTRL     = 3'd0;
    localparam logic [2:0] OFS_LOAD     = 3'd1;
    localparam logic [2:0] OFS_COUNT    = 3'd2;
    localparam logic [2:0] OFS_STATUS   = 3'd3;
    localparam logic [2:0] OFS_PRESCALE = 3'd4;

    logic                en_q, en_d;
    logic                auto_q, auto_d;
    logic                irq_en_q, irq_en_d;
    logic                expired_q, expired_d;
    logic [BusWidth-1:0] load_q, load_d;
    logic [BusWidth-1:0] count_q, count_d;
    logic [PreW-1:0]     prescale_q, prescale_d;
    logic [PreW-1:0]     pcnt_q, pcnt_d;

    logic       wr_en;
    logic       tick;
    logic       expire;
    logic [2:0] ofs;

    assign ofs    = i_Address[4:2];
    assign o_Hit  = (i_Address[BusWidth-1:5] == BaseAddr[BusWidth-1:5]);
    assign wr_en  = i_Mem_Write & o_Hit & (i_Address[1:0] == 2'b00);
    assign tick   = (pcnt_q == prescale_q);
    assign expire = en_q & tick & (count_q == '0);
    assign o_IRQ  = expired_q & irq_en_q;

    // Counting uses the pre-edge state; bus writes are applied afterwards so they win.
    always_comb begin
        en_d       = en_q;
        auto_d     = auto_q;
        irq_en_d   = irq_en_q;
        expired_d  = expired_q;
        load_d     = load_q;
        count_d    = count_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;

        if (en_q) begin
            if (tick) begin
                pcnt_d = '0;
                if (count_q != '0) begin
                    count_d = count_q - BusWidth'(1);
                end else begin
                    expired_d = 1'b1;
                    if (auto_q) begin
                        count_d = load_q;
                    end else begin
                        en_d = 1'b0;
                    end
                end
            end else begin
                pcnt_d = pcnt_q + PreW'(1);
            end
        end

        if (wr_en) begin
            case (ofs)
                OFS_CTRL: begin
                    en_d     = i_Write_Data[0];
                    auto_d   = i_Write_Data[1];
                    irq_en_d = i_Write_Data[2];
                    if (i_Write_Data[0] && !en_q) begin
                        count_d = load_q;
                        pcnt_d  = '0;
                    end
                end
                OFS_LOAD: begin
                    load_d = i_Write_Data;
                end
                OFS_STATUS: begin
                    // A same-cycle expiry keeps the flag set.
                    if (i_Write_Data[0] && !expire) begin
                        expired_d = 1'b0;
                    end
                end
                OFS_PRESCALE: begin
                    prescale_d = i_Write_Data[PreW-1:0];
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            expired_q  <= 1'b0;
            load_q     <= '0;
            count_q    <= '0;
            prescale_q <= '0;
            pcnt_q     <= '0;
        end else begin
            en_q       <= en_d;
            auto_q     <= auto_d;
            irq_en_q   <= irq_en_d;
            expired_q  <= expired_d;
            load_q     <= load_d;
            count_q    <= count_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
        end
    end

    // Read mux; reads ignore the byte offset within the word.
    always_comb begin
        o_Read_Data = '0;
        if (o_Hit) begin
            case (ofs)
                OFS_CTRL:     o_Read_Data = BusWidth'({irq_en_q, auto_q, en_q});
                OFS_LOAD:     o_Read_Data = load_q;
                OFS_COUNT:    o_Read_Data = count_q;
                OFS_STATUS:   o_Read_Data = BusWidth'(expired_q);
                OFS_PRESCALE: o_Read_Data = BusWidth'(prescale_q);
                default:      o_Read_Data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_arm_mmio_timer.sv
// Directed bench for arm_mmio_timer with an elapsed-time arithmetic model
// checked every cycle, plus hand-computed expectations for each scenario.
module tb_arm_mmio_timer;

    localparam logic [31:0] BASE     = 32'hFFFF_0000;
    localparam logic [31:0] A_CTRL   = BASE + 32'd0;
    localparam logic [31:0] A_LOAD   = BASE + 32'd4;
    localparam logic [31:0] A_COUNT  = BASE + 32'd8;
    localparam logic [31:0] A_STATUS = BASE + 32'd12;
    localparam logic [31:0] A_PRE    = BASE + 32'd16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mw;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    arm_mmio_timer #(.BusWidth(32), .BaseAddr(BASE)) dut (
        .i_CLK        (clk),
        .i_RESET      (rst),
        .i_Address    (addr),
        .i_Write_Data (wdata),
        .i_Mem_Write  (mw),
        .o_Read_Data  (rdata),
        .o_Hit        (hit),
        .o_IRQ        (irq)
    );

    // Model: a running timer is a segment (start edge, load value); its count
    // and expiry edge follow from elapsed edges divided by the prescale period.
    longint      cyc = 0;
    longint      seg_start = 0;
    logic [31:0] seg_load = 0;
    logic [31:0] m_load = 0;
    logic [31:0] m_hold = 0;
    logic [15:0] m_pre = 0;
    bit          m_en = 0, m_auto = 0, m_irq_en = 0, m_expired = 0;
    bit          old_en, new_en, exp_now;

    function automatic longint period();
        return longint'(m_pre) + 64'd1;
    endfunction

    function automatic logic [31:0] model_count(longint at);
        if (m_en) return seg_load - 32'((at - seg_start) / period());
        return m_hold;
    endfunction

    function automatic bit model_hit(logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd32);
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a);
        logic [2:0] o;
        o = a[4:2];
        if (!model_hit(a)) return 32'd0;
        case (o)
            3'd0:    return {29'd0, m_irq_en, m_auto, m_en};
            3'd1:    return m_load;
            3'd2:    return model_count(cyc);
            3'd3:    return {31'd0, m_expired};
            3'd4:    return {16'd0, m_pre};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_en = 0; m_auto = 0; m_irq_en = 0; m_expired = 0;
            m_load = 0; m_hold = 0; m_pre = 0; seg_start = 0; seg_load = 0;
        end else begin
            old_en  = m_en;
            exp_now = m_en && ((cyc - seg_start) == (longint'(seg_load) + 64'd1) * period());
            if (exp_now) begin
                m_expired = 1;
                if (m_auto) begin
                    seg_start = cyc;
                    seg_load  = m_load;
                end else begin
                    m_en   = 0;
                    m_hold = 32'd0;
                end
            end
            if (mw && model_hit(addr) && addr[1:0] == 2'b00) begin
                case (addr[4:2])
                    3'd0: begin
                        new_en = wdata[0];
                        if (new_en && !old_en) begin
                            seg_start = cyc;
                            seg_load  = m_load;
                        end else if (new_en && !m_en) begin
                            seg_start = cyc;
                            seg_load  = 32'd0;
                        end else if (!new_en && m_en) begin
                            m_hold = model_count(cyc);
                        end
                        m_en     = new_en;
                        m_auto   = wdata[1];
                        m_irq_en = wdata[2];
                    end
                    3'd1: m_load = wdata;
                    3'd3: if (wdata[0] && !exp_now) m_expired = 0;
                    3'd4: m_pre = wdata[15:0];
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("cmp_hit", 32'(hit), 32'(model_hit(addr)));
            check("cmp_rdata", rdata, model_read(addr));
            check("cmp_irq", 32'(irq), 32'(m_expired & m_irq_en));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        mw    = 1'b1;
        @(posedge clk);
        #1;
        mw = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        mw   = 1'b0;
        #1;
        check(nm, rdata, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mw  = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        addr  = BASE;
        wdata = 32'd0;
        mw    = 1'b0;
        step(2);
        rst = 1'b0;

        // Reset state
        for (int i = 0; i < 8; i++) begin
            rd("reset_reg", BASE + 32'(i * 4), 32'd0);
            if (i % 4 == 3) step(1);
        end
        check("reset_irq", 32'(irq), 32'd0);
        addr = BASE + 32'h20;
        #1;
        check("outside_hit", 32'(hit), 32'd0);
        check("outside_rdata", rdata, 32'd0);
        step(1);

        // One-shot, PRESCALE=0, LOAD=3
        wr(A_PRE, 32'd0);
        wr(A_LOAD, 32'd3);
        wr(A_CTRL, 32'h5);
        rd("oneshot_count", A_COUNT, 32'd3);
        for (int k = 2; k >= 0; k--) begin
            step(1);
            rd("oneshot_count", A_COUNT, 32'(k));
        end
        rd("oneshot_not_yet", A_STATUS, 32'd0);
        check("oneshot_irq_low", 32'(irq), 32'd0);
        step(1);
        rd("oneshot_expired", A_STATUS, 32'd1);
        check("oneshot_irq_high", 32'(irq), 32'd1);
        rd("oneshot_ctrl", A_CTRL, 32'h4);
        rd("oneshot_count0", A_COUNT, 32'd0);
        step(3);
        rd("oneshot_stays0", A_COUNT, 32'd0);
        check("oneshot_irq_level", 32'(irq), 32'd1);

        // Clear and expiry on the same edge
        do_reset();
        wr(A_LOAD, 32'd3);
        wr(A_CTRL, 32'h5);
        step(3);
        wr(A_STATUS, 32'd1);
        rd("collide_set_wins", A_STATUS, 32'd1);
        wr(A_STATUS, 32'd1);
        rd("clear_after", A_STATUS, 32'd0);
        check("clear_irq", 32'(irq), 32'd0);

        // Auto-reload with PRESCALE=1, LOAD=2: expiries at edges 6, 12, 18
        do_reset();
        wr(A_PRE, 32'd1);
        wr(A_LOAD, 32'd2);
        wr(A_CTRL, 32'h3);
        step(5);
        rd("auto_pre6", A_STATUS, 32'd0);
        step(1);
        rd("auto_exp6", A_STATUS, 32'd1);
        rd("auto_reload6", A_COUNT, 32'd2);
        wr(A_STATUS, 32'd1);
        rd("auto_clr7", A_STATUS, 32'd0);
        rd("auto_count7", A_COUNT, 32'd2);
        step(4);
        rd("auto_pre12", A_STATUS, 32'd0);
        step(1);
        rd("auto_exp12", A_STATUS, 32'd1);
        wr(A_STATUS, 32'd1);
        wr(A_LOAD, 32'd4);
        rd("auto_count14", A_COUNT, 32'd1);
        step(4);
        rd("auto_exp18", A_STATUS, 32'd1);
        rd("auto_newload18", A_COUNT, 32'd4);
        check("auto_irq_disabled", 32'(irq), 32'd0);

        // Stop and resume
        do_reset();
        wr(A_LOAD, 32'd10);
        wr(A_CTRL, 32'h1);
        step(4);
        rd("stop_before", A_COUNT, 32'd6);
        wr(A_CTRL, 32'h0);
        rd("stop_at5", A_COUNT, 32'd5);
        step(10);
        rd("stop_hold5", A_COUNT, 32'd5);
        wr(A_CTRL, 32'h1);
        rd("resume_reload", A_COUNT, 32'd10);
        step(1);
        rd("resume_runs", A_COUNT, 32'd9);
        wr(A_CTRL, 32'h0);

        // Bus rules
        do_reset();
        wr(A_LOAD, 32'hDEAD_BEEF);
        rd("load_readback", A_LOAD, 32'hDEAD_BEEF);
        wr(BASE + 32'd6, 32'h1234);
        rd("unaligned_load", A_LOAD, 32'hDEAD_BEEF);
        wr(BASE + 32'd2, 32'h1);
        rd("unaligned_ctrl", A_CTRL, 32'd0);
        wr(A_COUNT, 32'h55);
        rd("count_ro", A_COUNT, 32'd0);
        wr(BASE + 32'h20, 32'h1);
        rd("outside_write", A_CTRL, 32'd0);
        rd("read_ignores_lsb", BASE + 32'd5, 32'hDEAD_BEEF);
        wr(A_PRE, 32'hFFFF_1234);
        rd("prescale_16b", A_PRE, 32'h0000_1234);
        wr(A_CTRL, 32'hF8);
        rd("ctrl_upper", A_CTRL, 32'd0);
        wr(BASE + 32'd20, 32'h77);
        rd("reserved_off5", BASE + 32'd20, 32'd0);
        addr = BASE + 32'd28;
        #1;
        check("reserved_hit", 32'(hit), 32'd1);
        addr = BASE - 32'd4;
        #1;
        check("below_hit", 32'(hit), 32'd0);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
